// File: rtl/btn_capture_pkg.sv
// ---------------------------------------------------------------------------
// btn_capture_pkg
//
// Purpose: shared constants for the button capture Avalon-MM slave.
//   - Word addresses of the four registers in the slave's map.
//   - Width of the saturating press counter kept for button 0.
//   - Helper that tests whether the press counter has saturated.
// ---------------------------------------------------------------------------
package btn_capture_pkg;

    // Register word addresses on avs_address
    localparam logic [1:0] ADDR_DATA  = 2'd0;
    localparam logic [1:0] ADDR_EDGE  = 2'd1;
    localparam logic [1:0] ADDR_MASK  = 2'd2;
    localparam logic [1:0] ADDR_COUNT = 2'd3;

    // Width of the press counter for button 0
    localparam int COUNT_W = 16;

    // True when the press counter holds its maximum value and must not wrap
    function automatic logic count_saturated(input logic [COUNT_W-1:0] value);
        return (value == {COUNT_W{1'b1}});
    endfunction

endpackage : btn_capture_pkg

// File: rtl/btn_capture_debounce.sv
// ---------------------------------------------------------------------------
// btn_debounce
//
// Purpose: synchronise and debounce one button that has already been
// converted to "pressed = 1" polarity.
//
// Ports:
//   clk          in   system clock
//   reset        in   synchronous, active-high reset
//   pressed_raw  in   asynchronous pressed level from the pin
//   stable       out  debounced pressed level (0 after reset)
//   rise         out  one-cycle pulse in the cycle before stable goes 0 -> 1,
//                     so the owner can register the press on the same edge
//                     that stable changes
//
// The synchronised level has to differ from the accepted level for
// DEBOUNCE_CYCLES consecutive cycles before it is accepted; any return to
// the accepted level restarts the count.  Pin-to-stable latency is
// 2 + DEBOUNCE_CYCLES cycles.
// ---------------------------------------------------------------------------
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic clk,
    input  logic reset,
    input  logic pressed_raw,
    output logic stable,
    output logic rise
);

    // A counter of $clog2(DEBOUNCE_CYCLES) bits covers 0 .. DEBOUNCE_CYCLES-1
    localparam int CNT_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync_meta;
    logic             sync_q;
    logic             stable_q;
    logic [CNT_W-1:0] cnt_q;
    logic             accept;

    // The new level has been held long enough; take it on the coming edge
    assign accept = (sync_q != stable_q) && (cnt_q == CNT_LAST);

    // Two-flop synchroniser, hold counter and accepted level
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_meta <= 1'b0;
            sync_q    <= 1'b0;
            stable_q  <= 1'b0;
            cnt_q     <= '0;
        end else begin
            sync_meta <= pressed_raw;
            sync_q    <= sync_meta;
            if (sync_q == stable_q) begin
                cnt_q <= '0;
            end else if (accept) begin
                stable_q <= sync_q;
                cnt_q    <= '0;
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    assign stable = stable_q;
    assign rise   = accept & sync_q;

endmodule : btn_debounce

// File: rtl/button_capture_avs.sv
// ---------------------------------------------------------------------------
// button_capture_avs
//
// Purpose: Avalon-MM slave that brings up to 32 push-buttons into the Nios
// system.  Each button is synchronised and debounced, presses (0 -> 1 of the
// debounced level) are captured in a sticky write-1-to-clear register and
// raise a maskable level interrupt.  Presses of button 0 are also counted in
// a saturating 16-bit counter.
//
// Ports:
//   clk            in   system clock
//   reset          in   synchronous, active-high reset
//   btn_in         in   raw asynchronous button pins [WIDTH]
//   avs_address    in   register word address [2]
//   avs_read       in   read strobe
//   avs_readdata   out  read data [32], valid the cycle after avs_read,
//                       0 on every other cycle
//   avs_write      in   write strobe, takes effect on the strobe cycle
//   avs_writedata  in   write data [32]
//   irq            out  active-high level interrupt = |(EDGE & MASK)
//
// Register map:
//   0 DATA   RO   debounced pressed levels
//   1 EDGE   W1C  sticky press capture; a press beats a clear in the same cycle
//   2 MASK   RW   interrupt enable per button
//   3 COUNT  RW0  [15:0] presses of button 0, saturating; any write clears it,
//                 a coincident press leaves it at 1
// ---------------------------------------------------------------------------
module button_capture_avs
    import btn_capture_pkg::*;
#(
    parameter int WIDTH           = 1,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int ACTIVE_LOW      = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] btn_in,
    input  logic [1:0]       avs_address,
    input  logic             avs_read,
    output logic [31:0]      avs_readdata,
    input  logic             avs_write,
    input  logic [31:0]      avs_writedata,
    output logic             irq
);

    logic [WIDTH-1:0]   pressed_raw;
    logic [WIDTH-1:0]   stable;
    logic [WIDTH-1:0]   press;
    logic [WIDTH-1:0]   edge_q;
    logic [WIDTH-1:0]   mask_q;
    logic [COUNT_W-1:0] count_q;
    logic [31:0]        readdata_q;
    logic [31:0]        read_mux;
    logic               wr_edge;
    logic               wr_mask;
    logic               wr_count;
    logic               unused_wdata;

    // Normalise pin polarity so that 1 always means pressed
    assign pressed_raw = (ACTIVE_LOW != 0) ? ~btn_in : btn_in;

    // One synchroniser/debouncer per button
    for (genvar i = 0; i < WIDTH; i++) begin : g_debounce
        btn_debounce #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
        ) u_debounce (
            .clk         (clk),
            .reset       (reset),
            .pressed_raw (pressed_raw[i]),
            .stable      (stable[i]),
            .rise        (press[i])
        );
    end

    assign wr_edge  = avs_write && (avs_address == ADDR_EDGE);
    assign wr_mask  = avs_write && (avs_address == ADDR_MASK);
    assign wr_count = avs_write && (avs_address == ADDR_COUNT);

    // Only the low WIDTH bits of the write bus matter; the rest is ignored
    assign unused_wdata = ^avs_writedata;

    // Sticky press capture: clear first, then OR in presses so set wins
    always_ff @(posedge clk) begin
        if (reset) begin
            edge_q <= '0;
        end else if (wr_edge) begin
            edge_q <= (edge_q & ~avs_writedata[WIDTH-1:0]) | press;
        end else begin
            edge_q <= edge_q | press;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mask_q <= '0;
        end else if (wr_mask) begin
            mask_q <= avs_writedata[WIDTH-1:0];
        end
    end

    // Button 0 press counter; a write clears it but a coincident press
    // still counts, leaving 1
    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else if (wr_count) begin
            count_q <= press[0] ? COUNT_W'(1) : '0;
        end else if (press[0] && !count_saturated(count_q)) begin
            count_q <= count_q + COUNT_W'(1);
        end
    end

    // Read mux sees the registers before any same-cycle write lands
    always_comb begin
        read_mux = '0;
        case (avs_address)
            ADDR_DATA:  read_mux = 32'(stable);
            ADDR_EDGE:  read_mux = 32'(edge_q);
            ADDR_MASK:  read_mux = 32'(mask_q);
            ADDR_COUNT: read_mux = 32'(count_q);
            default:    read_mux = '0;
        endcase
    end

    // Fixed read latency of one; the bus idles at zero between reads
    always_ff @(posedge clk) begin
        if (reset) begin
            readdata_q <= '0;
        end else if (avs_read) begin
            readdata_q <= read_mux;
        end else begin
            readdata_q <= '0;
        end
    end

    assign avs_readdata = readdata_q;
    assign irq          = |(edge_q & mask_q);

endmodule : button_capture_avs

// File: tb/tb_button_capture_avs.sv
// ---------------------------------------------------------------------------
// tb_button_capture_avs
//
// Directed self-checking bench for button_capture_avs with WIDTH=4,
// DEBOUNCE_CYCLES=8, ACTIVE_LOW=1.  Inputs change on the falling clock edge
// and outputs are sampled on the falling edge after the active rising edge.
// With DEBOUNCE_CYCLES=8 a pin change made before rising edge 1 reaches the
// debounced level on rising edge 10.
// ---------------------------------------------------------------------------
module tb_button_capture_avs;

    logic        clk;
    logic        reset;
    logic [3:0]  btn_in;
    logic [1:0]  avs_address;
    logic        avs_read;
    logic [31:0] avs_readdata;
    logic        avs_write;
    logic [31:0] avs_writedata;
    logic        irq;

    int checks;
    int errors;

    button_capture_avs #(
        .WIDTH           (4),
        .DEBOUNCE_CYCLES (8),
        .ACTIVE_LOW      (1)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .btn_in        (btn_in),
        .avs_address   (avs_address),
        .avs_read      (avs_read),
        .avs_readdata  (avs_readdata),
        .avs_write     (avs_write),
        .avs_writedata (avs_writedata),
        .irq           (irq)
    );

    // 10 ns clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Single comparison point: counts the check and reports a mismatch
    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
        end
    endtask

    // Drive the button pins and let the given number of cycles pass
    task automatic applyStimulus(input logic [3:0] pins, input int cycles);
        btn_in = pins;
        repeat (cycles) @(negedge clk);
    endtask

    // One-cycle read; entered and left on a falling edge
    task automatic readReg(input logic [1:0] addr, output logic [31:0] data);
        avs_address = addr;
        avs_read    = 1'b1;
        @(negedge clk);
        avs_read = 1'b0;
        data     = avs_readdata;
    endtask

    // One-cycle write; entered and left on a falling edge
    task automatic writeReg(input logic [1:0] addr, input logic [31:0] data);
        avs_address   = addr;
        avs_writedata = data;
        avs_write     = 1'b1;
        @(negedge clk);
        avs_write = 1'b0;
    endtask

    // Keeps a broken design from hanging the run
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [31:0] rd;
        checks        = 0;
        errors        = 0;
        reset         = 1'b1;
        btn_in        = 4'hF;
        avs_address   = 2'd0;
        avs_read      = 1'b0;
        avs_write     = 1'b0;
        avs_writedata = 32'h0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        // Reset state
        checkOutput("reset_readdata", avs_readdata, 32'h0);
        checkOutput("reset_irq", {31'h0, irq}, 32'h0);
        for (int a = 0; a < 4; a++) begin
            readReg(2'(a), rd);
            checkOutput($sformatf("reset_reg%0d", a), rd, 32'h0);
        end

        // Press button 0 while reading DATA back to back
        btn_in      = 4'hE;
        avs_address = 2'd0;
        avs_read    = 1'b1;
        repeat (10) @(negedge clk);
        checkOutput("data_before_accept", avs_readdata, 32'h0);
        @(negedge clk);
        checkOutput("data_after_accept", avs_readdata, 32'h1);
        avs_read = 1'b0;
        @(negedge clk);
        checkOutput("readdata_idle_zero", avs_readdata, 32'h0);
        applyStimulus(4'hE, 8);
        readReg(2'd1, rd);
        checkOutput("edge_first_press", rd, 32'h1);
        readReg(2'd3, rd);
        checkOutput("count_first_press", rd, 32'h1);
        checkOutput("irq_masked", {31'h0, irq}, 32'h0);
        writeReg(2'd2, 32'h1);
        checkOutput("irq_after_mask", {31'h0, irq}, 32'h1);

        // Same-cycle read and write of MASK returns the old value
        avs_address   = 2'd2;
        avs_writedata = 32'hFFFF_FFFF;
        avs_read      = 1'b1;
        avs_write     = 1'b1;
        @(negedge clk);
        avs_read  = 1'b0;
        avs_write = 1'b0;
        checkOutput("mask_read_during_write", avs_readdata, 32'h1);
        readReg(2'd2, rd);
        checkOutput("mask_after_write", rd, 32'hF);
        writeReg(2'd2, 32'h1);

        // A 5-cycle glitch on button 2 is rejected
        applyStimulus(4'hA, 5);
        applyStimulus(4'hE, 12);
        readReg(2'd0, rd);
        checkOutput("glitch_data", rd, 32'h1);
        readReg(2'd1, rd);
        checkOutput("glitch_edge", rd, 32'h1);
        readReg(2'd3, rd);
        checkOutput("glitch_count", rd, 32'h1);

        // Release button 0, then clear EDGE on the very cycle of a new press
        applyStimulus(4'hF, 12);
        readReg(2'd0, rd);
        checkOutput("data_released", rd, 32'h0);
        applyStimulus(4'hE, 9);
        writeReg(2'd1, 32'h1);
        checkOutput("irq_set_beats_clear", {31'h0, irq}, 32'h1);
        readReg(2'd1, rd);
        checkOutput("edge_set_beats_clear", rd, 32'h1);
        readReg(2'd3, rd);
        checkOutput("count_second_press", rd, 32'h2);
        writeReg(2'd1, 32'h1);
        checkOutput("irq_after_clear", {31'h0, irq}, 32'h0);
        readReg(2'd1, rd);
        checkOutput("edge_after_clear", rd, 32'h0);

        // Saturation: preload the counter instead of 65534 real presses
        applyStimulus(4'hF, 12);
        force dut.count_q = 16'hFFFE;
        @(negedge clk);
        release dut.count_q;
        readReg(2'd3, rd);
        checkOutput("count_preload", rd, 32'hFFFE);
        applyStimulus(4'hE, 12);
        readReg(2'd3, rd);
        checkOutput("count_reach_max", rd, 32'hFFFF);
        applyStimulus(4'hF, 12);
        applyStimulus(4'hE, 12);
        readReg(2'd3, rd);
        checkOutput("count_saturated", rd, 32'hFFFF);

        // COUNT write on the same cycle as a press leaves 1
        applyStimulus(4'hF, 12);
        applyStimulus(4'hE, 9);
        writeReg(2'd3, 32'h0);
        readReg(2'd3, rd);
        checkOutput("count_write_with_press", rd, 32'h1);
        writeReg(2'd3, 32'h0);
        readReg(2'd3, rd);
        checkOutput("count_write_clears", rd, 32'h0);

        // Reset in the middle of debouncing button 1, button held through it
        applyStimulus(4'hF, 12);
        applyStimulus(4'hD, 5);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        writeReg(2'd2, 32'h2);
        avs_address = 2'd0;
        avs_read    = 1'b1;
        repeat (8) @(negedge clk);
        checkOutput("irq_before_reset_press", {31'h0, irq}, 32'h0);
        @(negedge clk);
        checkOutput("irq_reset_press", {31'h0, irq}, 32'h1);
        checkOutput("data_before_reset_press", avs_readdata, 32'h0);
        @(negedge clk);
        checkOutput("data_reset_press", avs_readdata, 32'h2);
        avs_read = 1'b0;
        readReg(2'd1, rd);
        checkOutput("edge_reset_press", rd, 32'h2);
        readReg(2'd3, rd);
        checkOutput("count_after_reset", rd, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_button_capture_avs
